// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: job-level MAC controller for a DSP48A1-style slice; define MACSEQ_STALL_CNT_EN to add the STALL_CNT output
module dsp_mac_sequencer #(
  parameter int LEN_W   = 8,
  parameter int DSP_LAT = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [LEN_W-1:0] LEN,
  input  logic             CFG_SUB,
  input  logic             CFG_PREADD,
  input  logic             CFG_PRESUB,
  input  logic             S_VALID,
  output logic             S_READY,
  input  logic [17:0]      S_A,
  input  logic [17:0]      S_B,
  input  logic [17:0]      S_D,
  output logic             BUSY,
  output logic             DONE,
  output logic [47:0]      RESULT,
  output logic [17:0]      DSP_A,
  output logic [17:0]      DSP_B,
  output logic [17:0]      DSP_D,
  output logic [7:0]       DSP_OPMODE,
  output logic             DSP_CE,
  output logic             DSP_RST,
`ifdef MACSEQ_STALL_CNT_EN
  output logic [15:0]      STALL_CNT,
`endif
  input  logic [47:0]      DSP_P
);
  localparam int OPM_DLY = DSP_LAT - 1;
  localparam int DW = $clog2(DSP_LAT) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t           state_q;
  logic [LEN_W-1:0] len_q, cnt_q;
  logic [DW-1:0]    dcnt_q;
  logic             sub_q, preadd_q, presub_q, done_q;
  logic [47:0]      result_q;
  logic [1:0]       tag_q [OPM_DLY];
  logic [1:0]       tag_d, tag_o;
  logic [3:0]       zx;
  logic             hs, start_ok, last_hs, last_drain;
  assign hs         = state_q == RUN && S_VALID;
  assign start_ok   = state_q == IDLE && START;
  assign last_hs    = hs && cnt_q == len_q - 1'b1;
  assign last_drain = state_q == DRAIN && dcnt_q == DW'(DSP_LAT - 1);
  // tag {vld, first}: 11 first sample, 10 later sample, 01 clear (empty job), 00 bubble
  assign tag_d = hs ? {1'b1, cnt_q == '0} : {1'b0, start_ok && LEN == '0};
  assign tag_o = tag_q[OPM_DLY-1];
  assign zx    = tag_o == 2'b11 ? 4'b0001 : tag_o == 2'b10 ? 4'b1001 : tag_o == 2'b01 ? 4'b0000 : 4'b1000;
  assign DSP_OPMODE = BUSY ? {sub_q, presub_q, 1'b0, preadd_q, zx} : {4'b0000, zx};
  assign DSP_A   = hs ? S_A : '0;
  assign DSP_B   = hs ? S_B : '0;
  assign DSP_D   = hs ? S_D : '0;
  assign S_READY = state_q == RUN;
  assign BUSY    = state_q != IDLE;
  assign DONE    = done_q;
  assign RESULT  = result_q;
  assign DSP_CE  = 1'b1;
  assign DSP_RST = RST;
  // job FSM: latch job, count handshakes, wait out the slice pipeline, capture P
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      len_q <= '0;
      cnt_q <= '0;
      dcnt_q <= '0;
      done_q <= 1'b0;
      {sub_q, preadd_q, presub_q} <= '0;
      if (state_q == IDLE) result_q <= '0;
    end else begin
      done_q <= last_drain;
      if (last_drain) result_q <= DSP_P;
      case (state_q)
        IDLE: if (START) begin
          len_q <= LEN;
          cnt_q <= '0;
          dcnt_q <= '0;
          {sub_q, preadd_q, presub_q} <= {CFG_SUB, CFG_PREADD, CFG_PRESUB};
          state_q <= LEN == '0 ? DRAIN : RUN;
        end
        RUN: begin
          if (hs) cnt_q <= cnt_q + 1'b1;
          if (last_hs) state_q <= DRAIN;
        end
        DRAIN: begin
          dcnt_q <= dcnt_q + 1'b1;
          if (last_drain) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // tag pipe aligns X/Z selection with M reaching the post-adder
  always_ff @(posedge CLK) begin
    tag_q[0] <= RST ? 2'b00 : tag_d;
    for (int i = 1; i < OPM_DLY; i++) tag_q[i] <= RST ? 2'b00 : tag_q[i-1];
  end
`ifdef MACSEQ_STALL_CNT_EN
  logic [15:0] stall_q;
  assign STALL_CNT = stall_q;
  // saturating count of RUN cycles without an offered operand set
  always_ff @(posedge CLK) begin
    if (RST || start_ok) stall_q <= '0;
    else if (state_q == RUN && !S_VALID && stall_q != 16'hFFFF) stall_q <= stall_q + 1'b1;
  end
`endif
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb_dsp_mac_sequencer: vector table, directed corner sequences and random jobs against a sum-of-products model
module tb_dsp_mac_sequencer;
  localparam int DSP_LAT = 3;
  logic CLK = 0, RST = 1, START = 0, CFG_SUB = 0, CFG_PREADD = 0, CFG_PRESUB = 0, S_VALID = 0;
  logic [7:0] LEN = 0;
  logic [17:0] S_A = 0, S_B = 0, S_D = 0;
  logic S_READY, BUSY, DONE, DSP_CE, DSP_RST;
  logic [47:0] RESULT, DSP_P;
  logic [17:0] DSP_A, DSP_B, DSP_D;
  logic [7:0] DSP_OPMODE;
`ifdef MACSEQ_STALL_CNT_EN
  logic [15:0] STALL_CNT;
`endif
  int total = 0, bad = 0, cyc = 0;

  typedef struct {
    int len;
    logic sub, preadd, presub;
    logic [17:0] a [8];
    logic [17:0] b [8];
    logic [17:0] d [8];
    int stall_at, stall_n;
    logic [47:0] exp_res;
  } job_t;

  dsp_mac_sequencer dut (
    .CLK(CLK), .RST(RST), .START(START), .LEN(LEN),
    .CFG_SUB(CFG_SUB), .CFG_PREADD(CFG_PREADD), .CFG_PRESUB(CFG_PRESUB),
    .S_VALID(S_VALID), .S_READY(S_READY), .S_A(S_A), .S_B(S_B), .S_D(S_D),
    .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT),
    .DSP_A(DSP_A), .DSP_B(DSP_B), .DSP_D(DSP_D), .DSP_OPMODE(DSP_OPMODE),
    .DSP_CE(DSP_CE), .DSP_RST(DSP_RST),
`ifdef MACSEQ_STALL_CNT_EN
    .STALL_CNT(STALL_CNT),
`endif
    .DSP_P(DSP_P)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // slice environment: A1/B1 (pre-adder before B1), MREG, PREG; OPMODE combinational
  logic [17:0] a1 = 0, b1 = 0;
  logic [35:0] m = 0;
  logic [47:0] p = 0, xx, zz;
  assign xx = DSP_OPMODE[1:0] == 2'b01 ? {12'b0, m} : 48'b0;
  assign zz = DSP_OPMODE[3:2] == 2'b10 ? p : 48'b0;
  assign DSP_P = p;
  always @(posedge CLK) begin
    if (DSP_RST) begin
      a1 <= 0; b1 <= 0; m <= 0; p <= 0;
    end else if (DSP_CE) begin
      a1 <= DSP_A;
      b1 <= !DSP_OPMODE[4] ? DSP_B : DSP_OPMODE[6] ? DSP_D - DSP_B : DSP_D + DSP_B;
      m  <= 36'($signed(a1) * $signed(b1));
      p  <= DSP_OPMODE[7] ? zz - xx : zz + xx;
    end
  end

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic job_t mk(input int n, input logic [2:0] cfg, input logic [71:0] a, input logic [71:0] b,
                              input logic [71:0] d, input int sa, input int sn, input logic [47:0] e);
    job_t j;
    j.len = n;
    {j.sub, j.preadd, j.presub} = cfg;
    for (int i = 0; i < 8; i++) begin
      j.a[i] = i < 4 ? a[18*i +: 18] : 18'd0;
      j.b[i] = i < 4 ? b[18*i +: 18] : 18'd0;
      j.d[i] = i < 4 ? d[18*i +: 18] : 18'd0;
    end
    j.stall_at = sa;
    j.stall_n = sn;
    j.exp_res = e;
    return j;
  endfunction

  // result = +/- sum of zero-extended 36-bit products (B replaced by D+/-B when pre-adding)
  function automatic logic [47:0] model(input job_t j);
    logic [47:0] acc = '0;
    logic [17:0] bb;
    logic signed [35:0] pr;
    for (int i = 0; i < j.len; i++) begin
      bb = j.preadd ? (j.presub ? j.d[i] - j.b[i] : j.d[i] + j.b[i]) : j.b[i];
      pr = $signed(j.a[i]) * $signed(bb);
      acc = acc + {12'b0, pr};
    end
    return j.sub ? -acc : acc;
  endfunction

  // starts at a negedge with the DUT idle, returns at the negedge where DONE is seen
  task automatic run_job(input job_t j, input string nm);
    int idx = 0, guard = 0, ref_cyc, left = j.stall_n;
    logic rdy_bad = 1'b0;
    START = 1'b1;
    LEN = 8'(j.len);
    {CFG_SUB, CFG_PREADD, CFG_PRESUB} = {j.sub, j.preadd, j.presub};
    ref_cyc = cyc;
    @(negedge CLK);
    START = 1'b0;
    chk({nm, " busy"}, BUSY, 1'b1);
    chk({nm, " done_low"}, DONE, 1'b0);
    while (idx < j.len && guard < 100) begin
      if (idx == j.stall_at && left > 0) begin
        S_VALID = 1'b0;
        left--;
      end else begin
        S_VALID = 1'b1;
        S_A = j.a[idx];
        S_B = j.b[idx];
        S_D = j.d[idx];
      end
      if (S_VALID && S_READY) begin
        idx++;
        ref_cyc = cyc;
      end
      guard++;
      @(negedge CLK);
    end
    S_VALID = 1'b0;
    chk({nm, " all_accepted"}, 48'(idx), 48'(j.len));
    guard = 0;
    while (!DONE && guard < 20) begin
      rdy_bad |= S_READY;
      guard++;
      @(negedge CLK);
    end
    chk({nm, " done_seen"}, DONE, 1'b1);
    chk({nm, " latency"}, 48'(cyc - ref_cyc), 48'(DSP_LAT + 1));
    chk({nm, " ready_in_drain"}, rdy_bad, 1'b0);
    chk({nm, " busy_at_done"}, BUSY, 1'b0);
    chk({nm, " result"}, RESULT, j.exp_res);
`ifdef MACSEQ_STALL_CNT_EN
    chk({nm, " stall_cnt"}, 48'(STALL_CNT), 48'(j.stall_n - left));
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    job_t tbl [5];
    job_t j;
    logic seen;
    tbl[0] = mk(4, 3'b000, {18'd4, 18'd3, 18'd2, 18'd1}, {18'd8, 18'd7, 18'd6, 18'd5}, 72'd0, 0, 0, 48'd70);
    tbl[1] = mk(4, 3'b000, {18'd4, 18'd3, 18'd2, 18'd1}, {18'd8, 18'd7, 18'd6, 18'd5}, 72'd0, 2, 2, 48'd70);
    tbl[2] = mk(2, 3'b100, {36'd0, 18'd4, 18'd3}, {36'd0, 18'd5, 18'd2}, 72'd0, 0, 0, 48'hFFFF_FFFF_FFE6);
    tbl[3] = mk(1, 3'b010, {54'd0, 18'd2}, {54'd0, 18'd3}, {54'd0, 18'd10}, 0, 0, 48'd26);
    tbl[4] = mk(1, 3'b011, {54'd0, 18'd2}, {54'd0, 18'd3}, {54'd0, 18'd10}, 0, 0, 48'd14);
    repeat (3) @(negedge CLK);
    chk("rst s_ready", S_READY, 1'b0);
    chk("rst busy", BUSY, 1'b0);
    chk("rst done", DONE, 1'b0);
    chk("rst result", RESULT, 48'd0);
    chk("rst dsp_a", DSP_A, 18'd0);
    chk("rst opmode", DSP_OPMODE, 8'h08);
    chk("rst ce", DSP_CE, 1'b1);
    chk("rst dsp_rst_hi", DSP_RST, 1'b1);
    RST = 1'b0;
    @(negedge CLK);
    chk("dsp_rst_lo", DSP_RST, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      run_job(tbl[k], $sformatf("tbl%0d", k));
    end
    // back-to-back: second START issued in the DONE cycle of the first job
    @(negedge CLK);
    run_job(tbl[0], "b2b_a");
    run_job(mk(1, 3'b000, {54'd0, 18'd5}, {54'd0, 18'd5}, 72'd0, 0, 0, 48'd25), "b2b_b");
    // reset after two of four handshakes
    @(negedge CLK);
    START = 1'b1;
    LEN = 8'd4;
    {CFG_SUB, CFG_PREADD, CFG_PRESUB} = 3'b000;
    @(negedge CLK);
    START = 1'b0;
    chk("rstjob ready", S_READY, 1'b1);
    S_VALID = 1'b1; S_A = 18'd1; S_B = 18'd5;
    @(negedge CLK);
    S_A = 18'd2; S_B = 18'd6;
    @(negedge CLK);
    S_VALID = 1'b0;
    RST = 1'b1;
    chk("rstjob dsp_rst", DSP_RST, 1'b1);
    @(negedge CLK);
    RST = 1'b0;
    chk("rstjob busy", BUSY, 1'b0);
    chk("rstjob ready_low", S_READY, 1'b0);
    chk("rstjob result_kept", RESULT, 48'd25);
    chk("rstjob opmode", DSP_OPMODE, 8'h08);
    seen = 1'b0;
    repeat (8) begin
      @(negedge CLK);
      seen |= DONE;
    end
    chk("rstjob no_done", seen, 1'b0);
    run_job(mk(1, 3'b000, {54'd0, 18'd7}, {54'd0, 18'd9}, 72'd0, 0, 0, 48'd63), "post_rst");
    @(negedge CLK);
    run_job(mk(0, 3'b000, 72'd0, 72'd0, 72'd0, 0, 0, 48'd0), "len0");
    // random jobs against the model
    for (int r = 0; r < 20; r++) begin
      j.len = int'($urandom_range(1, 8));
      {j.sub, j.preadd, j.presub} = 3'($urandom);
      for (int i = 0; i < 8; i++) begin
        j.a[i] = 18'($urandom);
        j.b[i] = 18'($urandom);
        j.d[i] = 18'($urandom);
      end
      j.stall_at = int'($urandom_range(0, j.len - 1));
      j.stall_n = int'($urandom_range(0, 3));
      j.exp_res = model(j);
      @(negedge CLK);
      run_job(j, $sformatf("rnd%0d", r));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dsp_mac_sequencer.md
Name: dsp_mac_sequencer

Overview:
- Job-level controller for one DSP48A1-style slice, configured with A0_REG=0, B0_REG=0, A1_REG=1, B1_REG=1, MREG=1, PREG=1.
- Accepts a job (START, LEN, config), streams LEN operand sets into the slice over a valid/ready interface and drives OPMODE per sample so the slice computes a multiply-accumulate.
- Waits out the slice pipeline, then returns the 48-bit accumulated P as RESULT with a one-cycle DONE pulse.
- Sits between a requesting controller/DMA and the DSP top.

Parameters:
- LEN_W, 8, width of the LEN job-length field.
- DSP_LAT, 3, cycles from A/B issue to P updated in the slice; must be >= 2. OPM_DLY = DSP_LAT-1 is derived from it.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous active-high reset.
- START  in  1  job request; sampled in IDLE only.
- LEN  in  LEN_W  number of samples in the job; latched on START.
- CFG_SUB  in  1  post-adder subtract (drives OPMODE[7]); latched on START.
- CFG_PREADD  in  1  use pre-adder (OPMODE[4]); latched on START.
- CFG_PRESUB  in  1  pre-adder subtract (OPMODE[6]); latched on START.
- S_VALID  in  1  operand set valid.
- S_READY  out  1  sequencer accepts an operand set.
- S_A, S_B, S_D  in  18 each  operands.
- BUSY  out  1  job in progress (RUN or DRAIN).
- DONE  out  1  one-cycle pulse; RESULT valid.
- RESULT  out  48  captured accumulator.
- DSP_A, DSP_B, DSP_D  out  18 each  to slice A/B/D.
- DSP_OPMODE  out  8  to slice opmode (combinational in slice).
- DSP_CE  out  1  to all slice CE inputs.
- DSP_RST  out  1  to all slice RST inputs.
- DSP_P  in  48  slice P output.

Behaviour:
- Reset values: state=IDLE; S_READY=0, BUSY=0, DONE=0, RESULT=0, DSP_A/B/D=0, DSP_OPMODE=8'h08, DSP_CE=1.
- DSP_RST = RST, combinational pass-through.
- States:
  - IDLE: if START, latch LEN and CFG, go to RUN. If LEN=0, go to DRAIN instead and issue one clear op (X=00, Z=00).
  - RUN: S_READY=1. Each S_VALID&S_READY handshake drives S_A/S_B/S_D onto DSP_A/B/D combinationally that cycle and increments the sample count. After the LEN-th handshake, go to DRAIN.
  - DRAIN: S_READY=0; count DSP_LAT cycles. On the last drain cycle, RESULT<=DSP_P, then go to IDLE.
  - DONE: high for the first IDLE cycle after DRAIN.
- BUSY=1 in RUN and DRAIN.
- Latency: last handshake at cycle t -> DONE high at t+DSP_LAT+1 (t+4 at default).
- OPMODE composition: {CFG_SUB, CFG_PRESUB, 1'b0, CFG_PREADD, Z[1:0], X[1:0]}. The CFG bits are static for the whole job. X/Z come from a tag pipe {vld, first} delayed OPM_DLY cycles from issue, so they align with M arriving at the post-adder:
  - vld & first: Z=00, X=01 (P = M; clears the previous job, no RSTP needed).
  - vld & !first: Z=10, X=01 (P = P ± M).
  - bubble (no handshake at issue): Z=10, X=00 (P held).
- Value in IDLE with no pending tags: 8'h08.
- Stalls: S_VALID low in RUN inserts bubbles. Result unaffected, no timeout.
- START outside IDLE is ignored; START in the DONE cycle is accepted (back-to-back jobs).
- RST mid-job: returns to IDLE next cycle, clears the tag pipe, no DONE pulse, RESULT retains its old value, slice reset via DSP_RST.
- LEN wrap: count is LEN_W bits; max job 2^LEN_W-1 samples.
- Arithmetic: the slice zero-extends M to 48 bits; the sequencer applies no extension or saturation.

Optional Feature:
- Macro MACSEQ_STALL_CNT_EN.
- Defined: adds output STALL_CNT (16 bits). It counts RUN cycles with S_VALID=0, saturates at 16'hFFFF, clears on accepted START and on RST, and holds after DONE.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- LEN=4, A={1,2,3,4}, B={5,6,7,8}, S_VALID always high -> RESULT=70; DONE 4 cycles after last handshake; S_READY=0 during DRAIN.
- Same job with S_VALID low 2 cycles between samples 2 and 3 -> RESULT=70; STALL_CNT=2 when MACSEQ_STALL_CNT_EN is defined.
- CFG_SUB=1, LEN=2, A={3,4}, B={2,5} -> RESULT=48'hFFFF_FFFF_FFE6 (-26).
- CFG_PREADD=1, LEN=1, D=10, B=3, A=2 -> RESULT=26; with CFG_PRESUB=1 -> RESULT=14.
- START in the DONE cycle of job 1 (result 70), job 2 LEN=1, A=5, B=5 -> RESULT=25, with no carry-over from job 1. Then LEN=0 -> RESULT=0, DONE after DSP_LAT+1 cycles.
- RST after 2 of 4 handshakes -> BUSY=0, S_READY=0, no DONE. Then LEN=1, A=7, B=9 -> RESULT=63.
